// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Defines the queued write entry and the protected register indices.
package regfile_writeback_arbiter_pkg;

    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int REG_ZERO   = 0;
    localparam int PC_REG_DEF = 29;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of ALU/MDU result inputs, register-file write port and status.
// master drives results and query_reg; slave is the arbiter itself.
interface regfile_writeback_arbiter_if #(
    parameter int DEPTH = 4
);
    import regfile_writeback_arbiter_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_W-1:0]  mdu_reg;
    logic [DATA_W-1:0] mdu_data;
    logic              alu_stall;
    logic              Reg_write;
    logic [REG_W-1:0]  Write_Register;
    logic [DATA_W-1:0] Write_data;
    logic [REG_W-1:0]  query_reg;
    logic              query_pending;
    logic [CW-1:0]     fifo_count;
    logic              err_pc_write;
    logic              err_stall_ignored;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mdu_valid, mdu_reg, mdu_data,
        output query_reg,
        input  mdu_ready, alu_stall,
        input  Reg_write, Write_Register, Write_data,
        input  query_pending, fifo_count,
        input  err_pc_write, err_stall_ignored
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mdu_valid, mdu_reg, mdu_data,
        input  query_reg,
        output mdu_ready, alu_stall,
        output Reg_write, Write_Register, Write_data,
        output query_pending, fifo_count,
        output err_pc_write, err_stall_ignored
    );

endinterface

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// Circular buffer of pending MDU write-back entries.
// Ports: push/pop strobes, head entry, occupancy, per-slot valid and regs.
module wb_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  wb_entry_t              push_ent_i,
    input  logic                   pop_i,
    output wb_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [DEPTH-1:0]       vld_o,
    output logic [DEPTH*REG_W-1:0] regs_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        // Slots are cleared before set: push and pop never share a
        // slot because push is blocked when full and pop when empty.
        if (pop_i) begin
            rptr_d        = rptr_q + 1'b1;
            vld_d[rptr_q] = 1'b0;
        end
        if (push_i) begin
            wptr_d        = wptr_q + 1'b1;
            vld_d[wptr_q] = 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    // Payload needs no reset: vld_q/cnt_q gate every use of it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_ent_i;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            regs_o[i*REG_W +: REG_W] = mem_q[i].rd;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign vld_o   = vld_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and queued MDU results onto the register-file write port.
// Ports: clk, Reset (async, active low), bus (slave side of the bundle).
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int PC_REG       = PC_REG_DEF
) (
    input  logic                         clk,
    input  logic                         Reset,
    regfile_writeback_arbiter_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t              head;
    wb_entry_t              push_ent;
    wb_entry_t              gnt_ent;
    logic [CW-1:0]          count;
    logic [DEPTH-1:0]       vld;
    logic [DEPTH*REG_W-1:0] regs;

    logic ready;
    logic empty;
    logic push;
    logic pop;
    logic grant;
    logic is_zero;
    logic is_pc;
    logic hit;

    logic              we_q, we_d;
    logic [REG_W-1:0]  wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [SW-1:0]     starve_inc;
    logic              stall_q, stall_d;
    logic              epc_q, epc_d;
    logic              est_q, est_d;

    assign empty    = (count == '0);
    assign ready    = (count != CW'(DEPTH));
    assign push     = bus.mdu_valid & ready;
    assign pop      = ~bus.alu_valid & ~empty;
    assign grant    = bus.alu_valid | pop;
    assign push_ent = '{rd: bus.mdu_reg, data: bus.mdu_data};

    assign gnt_ent = bus.alu_valid
        ? wb_entry_t'{rd: bus.alu_reg, data: bus.alu_data}
        : head;

    assign is_zero = (gnt_ent.rd == REG_W'(REG_ZERO));
    assign is_pc   = (gnt_ent.rd == REG_W'(PC_REG));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (Reset),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .vld_o      (vld),
        .regs_o     (regs)
    );

    assign starve_inc = starve_q + 1'b1;

    always_comb begin
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        starve_d = starve_q;
        stall_d  = 1'b0;
        epc_d    = epc_q;
        est_d    = est_q;

        // Protected targets still consume the slot, just without a write.
        if (grant) begin
            we_d = ~is_zero & ~is_pc;
            if (we_d) begin
                wa_d = gnt_ent.rd;
                wd_d = gnt_ent.data;
            end
            if (is_pc) begin
                epc_d = 1'b1;
            end
        end

        if (stall_q & bus.alu_valid) begin
            est_d = 1'b1;
        end

        // Counts only cycles where a queued entry lost to the ALU.
        if (pop | empty) begin
            starve_d = '0;
        end else if (bus.alu_valid) begin
            if (starve_inc == SW'(STARVE_LIMIT)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            epc_q    <= 1'b0;
            est_q    <= 1'b0;
        end else begin
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            epc_q    <= epc_d;
            est_q    <= est_d;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && regs[i*REG_W +: REG_W] == bus.query_reg) begin
                hit = 1'b1;
            end
        end
    end

    assign bus.query_pending =
        hit & (bus.query_reg != REG_W'(REG_ZERO));

    assign bus.mdu_ready         = ready;
    assign bus.alu_stall         = stall_q;
    assign bus.Reg_write         = we_q;
    assign bus.Write_Register    = wa_q;
    assign bus.Write_data        = wd_q;
    assign bus.fifo_count        = count;
    assign bus.err_pc_write      = epc_q;
    assign bus.err_stall_ignored = est_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomised and directed checks of the write-back arbiter
// against a queue-based reference model.
module tb_regfile_writeback_arbiter;
    import regfile_writeback_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int PCR   = 29;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_writeback_arbiter_if #(.DEPTH(DEPTH)) bus ();

    regfile_writeback_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .PC_REG       (PCR)
    ) dut (
        .clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    wb_entry_t q[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_cnt;
    logic        m_stall;
    logic        m_epc;
    logic        m_est;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        q.delete();
        m_we = 0; m_wa = 0; m_wd = 0;
        m_cnt = 0; m_stall = 0; m_epc = 0; m_est = 0;
    endfunction

    function automatic logic m_pending(input logic [4:0] r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_update(input logic av, input logic [4:0] ar,
                                     input logic [31:0] ad, input logic mv,
                                     input logic [4:0] mr,
                                     input logic [31:0] md);
        int        pre;
        logic      pop;
        wb_entry_t g;
        pre = q.size();
        pop = !av && pre > 0;
        g = '{rd: ar, data: ad};
        if (pop) g = q.pop_front();
        m_we = 0;
        if (av || pop) begin
            if (g.rd != 0 && g.rd != PCR) begin
                m_we = 1; m_wa = g.rd; m_wd = g.data;
            end
            if (g.rd == PCR) m_epc = 1;
        end
        if (m_stall && av) m_est = 1;
        if (pop || pre == 0) begin
            m_cnt = 0; m_stall = 0;
        end else begin
            m_cnt++;
            m_stall = (m_cnt == LIMIT);
            if (m_stall) m_cnt = 0;
        end
        if (mv && pre < DEPTH) q.push_back('{rd: mr, data: md});
    endfunction

    task automatic chk_regs();
        chk("reg_write", 32'(bus.Reg_write), 32'(m_we));
        if (m_we) begin
            chk("write_reg", 32'(bus.Write_Register), 32'(m_wa));
            chk("write_data", bus.Write_data, m_wd);
        end
        chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        chk("alu_stall", 32'(bus.alu_stall), 32'(m_stall));
        chk("err_pc", 32'(bus.err_pc_write), 32'(m_epc));
        chk("err_stall", 32'(bus.err_stall_ignored), 32'(m_est));
    endtask

    // Called at a negedge (+optional skew); returns at the next negedge.
    task automatic step(input logic av, input logic [4:0] ar,
                        input logic [31:0] ad, input logic mv,
                        input logic [4:0] mr, input logic [31:0] md,
                        input logic [4:0] qr);
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mdu_valid = mv; bus.mdu_reg = mr; bus.mdu_data = md;
        bus.query_reg = qr;
        #1;
        chk("mdu_ready", 32'(bus.mdu_ready), 32'(q.size() != DEPTH));
        chk("query_pending", 32'(bus.query_pending), 32'(m_pending(qr)));
        m_update(av, ar, ad, mv, mr, md);
        @(negedge clk);
        chk_regs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        bus.alu_valid = 0; bus.alu_reg = 0; bus.alu_data = 0;
        bus.mdu_valid = 0; bus.mdu_reg = 0; bus.mdu_data = 0;
        bus.query_reg = 0;
        rst_n = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_write_reg", 32'(bus.Write_Register), 0);
        chk("rst_write_data", bus.Write_data, 0);
        chk("rst_ready", 32'(bus.mdu_ready), 1);
        chk_regs();
        rst_n = 1;
    endtask

    initial begin
        do_reset();

        // single ALU write
        step(1, 5, 32'h1234, 0, 0, 0, 0);
        chk("alu_we", 32'(bus.Reg_write), 1);
        chk("alu_reg", 32'(bus.Write_Register), 5);
        chk("alu_data", bus.Write_data, 32'h0000_1234);
        idle();
        chk("alu_we_off", 32'(bus.Reg_write), 0);

        // fill FIFO behind a busy ALU, then drain in order
        for (int i = 0; i < 4; i++)
            step(1, 1, 32'(i), 1, 5'(8 + i), 32'hA0 + 32'(i), 0);
        #1;
        chk("full_ready", 32'(bus.mdu_ready), 0);
        chk("full_count", 32'(bus.fifo_count), 4);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("drain_we", 32'(bus.Reg_write), 1);
            chk("drain_reg", 32'(bus.Write_Register), 32'(8 + i));
        end
        idle();

        // starvation: stall honoured
        step(1, 2, 32'h2, 1, 20, 32'h20, 0);
        repeat (LIMIT) step(1, 3, 32'h3, 0, 0, 0, 0);
        chk("stall_pulse", 32'(bus.alu_stall), 1);
        idle();
        chk("stall_fifo_reg", 32'(bus.Write_Register), 20);
        chk("stall_clear", 32'(bus.alu_stall), 0);

        // starvation: stall ignored
        step(1, 2, 32'h2, 1, 21, 32'h21, 0);
        repeat (LIMIT) step(1, 3, 32'h3, 0, 0, 0, 0);
        chk("stall_pulse2", 32'(bus.alu_stall), 1);
        step(1, 22, 32'h22, 0, 0, 0, 0);
        chk("ignored_reg", 32'(bus.Write_Register), 22);
        chk("ignored_flag", 32'(bus.err_stall_ignored), 1);
        idle();
        idle();

        // protected registers
        step(1, 5'(PCR), 32'hDEAD, 0, 0, 0, 0);
        chk("pc_no_write", 32'(bus.Reg_write), 0);
        chk("pc_err", 32'(bus.err_pc_write), 1);
        step(0, 0, 0, 1, 0, 32'hBEEF, 0);
        idle();
        chk("r0_no_write", 32'(bus.Reg_write), 0);
        chk("r0_count", 32'(bus.fifo_count), 0);

        // hazard query
        step(1, 1, 0, 1, 7, 32'h7, 0);
        step(1, 1, 0, 1, 12, 32'hC, 12);
        bus.query_reg = 12;
        #1;
        chk("query_hit", 32'(bus.query_pending), 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 12);
        bus.query_reg = 12;
        #1;
        chk("query_gone", 32'(bus.query_pending), 0);
        bus.query_reg = 0;
        #1;
        chk("query_zero", 32'(bus.query_pending), 0);
        @(negedge clk);

        // async reset mid-drain
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 1, 5'(3 + i), 32'(i), 0);
        idle();
        chk("pre_rst_we", 32'(bus.Reg_write), 1);
        chk("pre_rst_cnt", 32'(bus.fifo_count), 3);
        #2;
        rst_n = 0;
        #1;
        chk("async_we", 32'(bus.Reg_write), 0);
        chk("async_cnt", 32'(bus.fifo_count), 0);
        chk("async_ready", 32'(bus.mdu_ready), 1);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (4) idle();

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic av;
            av = ($urandom_range(0, 99) < 55);
            if (m_stall && $urandom_range(0, 9) != 0) av = 0;
            step(av, 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                 $urandom(), 5'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
